// File: rtl/mem_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter_if
// Bundles the requester-side and memory-side buses of mem_rr_arbiter.
//
// Requester side (one lane per requester, lane i at [i*AW +: AW] etc.):
//   m_req    level request, m_wr write(1)/read(0), m_addr, m_wdata
//   m_rdy    one-cycle completion pulse, m_err one-cycle timeout pulse
//   m_rdata  read data of the most recent completed read (shared)
// Memory side:
//   mem_req/mem_wr/mem_addr/mem_dout  command, held stable until mem_rdy
//   mem_rdy/mem_din                   one-cycle completion with read data
//
// Handshake: a requester raises m_req with its command fields and keeps them
// valid until the arbiter latches them (the edge after which mem_req rises);
// the arbiter answers with exactly one m_rdy pulse per granted command.
// On the memory side mem_req stays high with a stable command until the
// memory returns a single-cycle mem_rdy (or the watchdog aborts).
//
// Modports: slave = arbiter view, master = requesters + memory model view.
// ---------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 64,
    parameter int DW   = 64
);
    logic [NREQ-1:0]    m_req;
    logic [NREQ-1:0]    m_wr;
    logic [NREQ*AW-1:0] m_addr;
    logic [NREQ*DW-1:0] m_wdata;
    logic [NREQ-1:0]    m_rdy;
    logic [NREQ-1:0]    m_err;
    logic [DW-1:0]      m_rdata;

    logic               mem_req;
    logic               mem_wr;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_dout;
    logic               mem_rdy;
    logic [DW-1:0]      mem_din;

    modport slave (
        input  m_req, m_wr, m_addr, m_wdata, mem_rdy, mem_din,
        output m_rdy, m_err, m_rdata, mem_req, mem_wr, mem_addr, mem_dout
    );

    modport master (
        output m_req, m_wr, m_addr, m_wdata, mem_rdy, mem_din,
        input  m_rdy, m_err, m_rdata, mem_req, mem_wr, mem_addr, mem_dout
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Round-robin arbiter sharing one memory port between NREQ requesters.
// One command is latched, driven to memory until mem_rdy, and completion
// (plus read data) is returned to the granted requester. A watchdog aborts
// a command whose mem_rdy does not arrive within TIMEOUT WAIT cycles.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   bus           mem_rr_arbiter_if.slave (requester + memory buses)
//   o_busy        high in ISSUE/WAIT/DONE
//   o_grant_id    current/last granted requester
//   o_err_sticky  set on any timeout, cleared only by reset
//   o_state       FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    mem_rr_arbiter_if.slave         bus,
    output logic                    o_busy,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_err_sticky,
    output logic [1:0]              o_state
);
    localparam int IW  = $clog2(NREQ);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] TO_V  = WDW'(TIMEOUT);
    localparam logic [IW-1:0]  LAST  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic            r_mem_req,   w_mem_req_nxt;
    logic            r_mem_wr,    w_mem_wr_nxt;
    logic [AW-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_dout,  w_mem_dout_nxt;
    logic            r_cmd_wr,    w_cmd_wr_nxt;
    logic [NREQ-1:0] r_m_rdy,     w_m_rdy_nxt;
    logic [NREQ-1:0] r_m_err,     w_m_err_nxt;
    logic [DW-1:0]   r_m_rdata,   w_m_rdata_nxt;
    logic            r_busy,      w_busy_nxt;
    logic [IW-1:0]   r_grant,     w_grant_nxt;
    logic [IW-1:0]   r_ptr,       w_ptr_nxt;
    logic [WDW-1:0]  r_wd,        w_wd_nxt;
    logic            r_sticky,    w_sticky_nxt;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_ptr_after;
    logic [WDW-1:0]  w_wd_inc;

    // Rotating priority scan: first set request starting at r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.m_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // The requester after the one just served gets top priority next time.
    assign w_ptr_after = (r_grant == LAST) ? '0 : r_grant + 1'b1;
    assign w_wd_inc    = r_wd + 1'b1;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_wr_nxt   = r_mem_wr;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_dout_nxt = r_mem_dout;
        w_cmd_wr_nxt   = r_cmd_wr;
        w_m_rdy_nxt    = '0;
        w_m_err_nxt    = '0;
        w_m_rdata_nxt  = r_m_rdata;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_wd_nxt       = r_wd;
        w_sticky_nxt   = r_sticky;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    // The memory command registers double as the holding
                    // registers, so later requester changes are ignored.
                    w_state_nxt    = S_ISSUE;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_wr_nxt   = bus.m_wr[w_sel];
                    w_cmd_wr_nxt   = bus.m_wr[w_sel];
                    w_mem_addr_nxt = bus.m_addr[int'(w_sel)*AW +: AW];
                    w_mem_dout_nxt = bus.m_wdata[int'(w_sel)*DW +: DW];
                    w_grant_nxt    = w_sel;
                    w_wd_nxt       = '0;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (bus.mem_rdy) begin
                    w_state_nxt          = S_DONE;
                    w_mem_req_nxt        = 1'b0;
                    w_mem_wr_nxt         = 1'b0;
                    w_m_rdy_nxt[r_grant] = 1'b1;
                    w_ptr_nxt            = w_ptr_after;
                    if (!r_cmd_wr) begin
                        w_m_rdata_nxt = bus.mem_din;
                    end
                end else if (r_state == S_ISSUE) begin
                    w_state_nxt = S_WAIT;
                end else if ((TIMEOUT != 0) && (w_wd_inc == TO_V)) begin
                    // Watchdog abort: complete with error, keep old read data.
                    w_state_nxt          = S_DONE;
                    w_mem_req_nxt        = 1'b0;
                    w_mem_wr_nxt         = 1'b0;
                    w_m_rdy_nxt[r_grant] = 1'b1;
                    w_m_err_nxt[r_grant] = 1'b1;
                    w_sticky_nxt         = 1'b1;
                    w_ptr_nxt            = w_ptr_after;
                end else begin
                    w_wd_nxt = w_wd_inc;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
            r_cmd_wr   <= 1'b0;
            r_m_rdy    <= '0;
            r_m_err    <= '0;
            r_m_rdata  <= '0;
            r_busy     <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_wd       <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_cmd_wr   <= w_cmd_wr_nxt;
            r_m_rdy    <= w_m_rdy_nxt;
            r_m_err    <= w_m_err_nxt;
            r_m_rdata  <= w_m_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_grant    <= w_grant_nxt;
            r_ptr      <= w_ptr_nxt;
            r_wd       <= w_wd_nxt;
            r_sticky   <= w_sticky_nxt;
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_wr   = r_mem_wr;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_dout = r_mem_dout;
    assign bus.m_rdy    = r_m_rdy;
    assign bus.m_err    = r_m_err;
    assign bus.m_rdata  = r_m_rdata;
    assign o_busy       = r_busy;
    assign o_grant_id   = r_grant;
    assign o_err_sticky = r_sticky;
    assign o_state      = r_state;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Directed testbench for mem_rr_arbiter (NREQ=4, AW=DW=64, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int TO   = 8;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_sticky;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    mem_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus.slave),
        .o_busy       (busy),
        .o_grant_id   (grant_id),
        .o_err_sticky (err_sticky),
        .o_state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_lane(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.m_addr[id*AW +: AW]  = addr;
        bus.m_wdata[id*DW +: DW] = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr: got %0b expected 0", bus.mem_wr); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (bus.m_rdy !== 4'b0000) begin n_errors++; $display("FAIL reset_m_rdy: got %b expected 0000", bus.m_rdy); end
        n_checks++; if (bus.m_err !== 4'b0000) begin n_errors++; $display("FAIL reset_m_err: got %b expected 0000", bus.m_err); end
        n_checks++; if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_sticky: got %0b expected 0", err_sticky); end
        n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_checks++; if (bus.m_rdata !== 64'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", bus.m_rdata); end
        n_checks++; if (bus.mem_addr !== 64'h0 || bus.mem_dout !== 64'h0) begin n_errors++; $display("FAIL reset_addr_dout: got %h/%h expected 0/0", bus.mem_addr, bus.mem_dout); end
        n_checks++; if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        set_lane(0, 64'h10, 64'h0);
        bus.m_wr  = 4'b0000;
        bus.m_req = 4'b0001;
        tick();  // ISSUE
        bus.m_req = 4'b0000;
        n_checks++; if (bus.mem_req !== 1'b1) begin n_errors++; $display("FAIL rd_issue_req: got %0b expected 1", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 64'h10) begin n_errors++; $display("FAIL rd_issue_addr: got %h expected 10", bus.mem_addr); end
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_errors++; $display("FAIL rd_issue_wr: got %0b expected 0", bus.mem_wr); end
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1 || state !== 2'd1) begin n_errors++; $display("FAIL rd_issue_status: got grant %0d busy %0b state %0d expected 0 1 1", grant_id, busy, state); end
        tick();  // WAIT1
        n_checks++; if (bus.mem_req !== 1'b1 || bus.m_rdy !== 4'b0000) begin n_errors++; $display("FAIL rd_wait1: got req %0b rdy %b expected 1 0000", bus.mem_req, bus.m_rdy); end
        tick();  // WAIT2
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'hDEADBEEF_00000001;
        tick();  // DONE
        bus.mem_rdy = 1'b0;
        bus.mem_din = 64'h0;
        n_checks++; if (bus.m_rdy !== 4'b0001) begin n_errors++; $display("FAIL rd_done_rdy: got %b expected 0001", bus.m_rdy); end
        n_checks++; if (bus.m_rdata !== 64'hDEADBEEF_00000001) begin n_errors++; $display("FAIL rd_done_rdata: got %h expected deadbeef00000001", bus.m_rdata); end
        n_checks++; if (bus.mem_req !== 1'b0 || bus.m_err !== 4'b0000) begin n_errors++; $display("FAIL rd_done_req_err: got %0b %b expected 0 0000", bus.mem_req, bus.m_err); end
        tick();  // IDLE
        n_checks++; if (bus.m_rdy !== 4'b0000 || busy !== 1'b0) begin n_errors++; $display("FAIL rd_idle: got rdy %b busy %0b expected 0000 0", bus.m_rdy, busy); end
    endtask

    task automatic test_single_write();
        set_lane(2, 64'h1FFF, 64'h5);
        bus.m_wr  = 4'b0100;
        bus.m_req = 4'b0100;
        tick();  // ISSUE
        n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 64'h5 || bus.mem_addr !== 64'h1FFF) begin n_errors++; $display("FAIL wr_issue_cmd: got wr %0b dout %h addr %h expected 1 5 1fff", bus.mem_wr, bus.mem_dout, bus.mem_addr); end
        n_checks++; if (grant_id !== 2'd2) begin n_errors++; $display("FAIL wr_issue_grant: got %0d expected 2", grant_id); end
        // Change the requester lane after grant; the latched command must not move.
        bus.m_req = 4'b0000;
        bus.m_wr  = 4'b0000;
        set_lane(2, 64'hBAD0, 64'hAA);
        tick();  // WAIT1
        tick();  // WAIT2
        n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 64'h5 || bus.mem_addr !== 64'h1FFF || bus.mem_req !== 1'b1) begin n_errors++; $display("FAIL wr_wait_stable: got req %0b wr %0b dout %h addr %h expected 1 1 5 1fff", bus.mem_req, bus.mem_wr, bus.mem_dout, bus.mem_addr); end
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'h1234;
        tick();  // DONE
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b0100) begin n_errors++; $display("FAIL wr_done_rdy: got %b expected 0100", bus.m_rdy); end
        n_checks++; if (bus.m_rdata !== 64'hDEADBEEF_00000001) begin n_errors++; $display("FAIL wr_done_rdata: got %h expected deadbeef00000001", bus.m_rdata); end
        n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_wr !== 1'b0) begin n_errors++; $display("FAIL wr_done_drop: got req %0b wr %0b expected 0 0", bus.mem_req, bus.mem_wr); end
        tick();  // IDLE
    endtask

    task automatic test_round_robin();
        int exp_id [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0] exp_rdy;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < NREQ; r++) set_lane(r, 64'h1000 + 64'(r), 64'h0);
        bus.m_wr  = 4'b0000;
        bus.m_req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            int cyc = 0;
            while (bus.mem_req !== 1'b1 && cyc < 8) begin
                tick();
                cyc++;
            end
            n_checks++;
            if (bus.mem_req !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_wait_req_%0d: got mem_req %0b expected 1 within 8 cycles", i, bus.mem_req);
                bus.m_req = 4'b0000;
                return;
            end
            n_checks++; if (grant_id !== 2'(exp_id[i])) begin n_errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, grant_id, exp_id[i]); end
            n_checks++; if (bus.mem_addr !== 64'h1000 + 64'(exp_id[i])) begin n_errors++; $display("FAIL rr_addr_%0d: got %h expected %h", i, bus.mem_addr, 64'h1000 + 64'(exp_id[i])); end
            // Odd iterations complete in the ISSUE cycle, even ones one cycle later.
            if (i % 2 == 0) tick();
            bus.mem_rdy = 1'b1;
            bus.mem_din = 64'h100 + 64'(i);
            tick();  // DONE
            bus.mem_rdy = 1'b0;
            if (i == 5) bus.m_req = 4'b0000;
            exp_rdy = 4'b0001 << exp_id[i];
            n_checks++; if (bus.m_rdy !== exp_rdy) begin n_errors++; $display("FAIL rr_rdy_%0d: got %b expected %b", i, bus.m_rdy, exp_rdy); end
            n_checks++; if (bus.m_rdata !== 64'h100 + 64'(i)) begin n_errors++; $display("FAIL rr_rdata_%0d: got %h expected %h", i, bus.m_rdata, 64'h100 + 64'(i)); end
            tick();  // IDLE
        end
    endtask

    task automatic test_timeout();
        set_lane(1, 64'h2222, 64'h0);
        bus.m_wr  = 4'b0000;
        bus.m_req = 4'b0010;
        tick();  // ISSUE
        bus.m_req = 4'b0000;
        n_checks++; if (grant_id !== 2'd1) begin n_errors++; $display("FAIL to_grant: got %0d expected 1", grant_id); end
        for (int k = 0; k < TO; k++) tick();  // WAIT1..WAIT8
        n_checks++; if (bus.mem_req !== 1'b1 || bus.m_err !== 4'b0000 || state !== 2'd2) begin n_errors++; $display("FAIL to_wait8: got req %0b err %b state %0d expected 1 0000 2", bus.mem_req, bus.m_err, state); end
        tick();  // DONE
        n_checks++; if (bus.mem_req !== 1'b0) begin n_errors++; $display("FAIL to_drop: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.m_rdy !== 4'b0010 || bus.m_err !== 4'b0010) begin n_errors++; $display("FAIL to_pulse: got rdy %b err %b expected 0010 0010", bus.m_rdy, bus.m_err); end
        n_checks++; if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %0b expected 1", err_sticky); end
        n_checks++; if (bus.m_rdata !== 64'h105) begin n_errors++; $display("FAIL to_rdata: got %h expected 105", bus.m_rdata); end
        tick();  // IDLE
        n_checks++; if (bus.m_rdy !== 4'b0000 || bus.m_err !== 4'b0000 || err_sticky !== 1'b1) begin n_errors++; $display("FAIL to_idle: got rdy %b err %b sticky %0b expected 0000 0000 1", bus.m_rdy, bus.m_err, err_sticky); end
        // Next requester (pointer now at 2) is served normally.
        bus.m_req = 4'b1100;
        tick();  // ISSUE
        bus.m_req = 4'b0000;
        n_checks++; if (grant_id !== 2'd2) begin n_errors++; $display("FAIL to_next_grant: got %0d expected 2", grant_id); end
        tick();  // WAIT1
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'hCAFE;
        tick();  // DONE
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b0100 || bus.m_err !== 4'b0000 || bus.m_rdata !== 64'hCAFE) begin n_errors++; $display("FAIL to_next_done: got rdy %b err %b rdata %h expected 0100 0000 cafe", bus.m_rdy, bus.m_err, bus.m_rdata); end
        tick();  // IDLE
    endtask

    task automatic test_reset_mid_op();
        bus.m_req = 4'b0001;
        tick();  // ISSUE (pointer at 3 wraps to requester 0)
        bus.m_req = 4'b0000;
        tick();  // WAIT1
        n_checks++; if (state !== 2'd2 || grant_id !== 2'd0) begin n_errors++; $display("FAIL rst_pre: got state %0d grant %0d expected 2 0", state, grant_id); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || bus.m_rdy !== 4'b0000 || err_sticky !== 1'b0) begin n_errors++; $display("FAIL rst_mid: got req %0b busy %0b grant %0d rdy %b sticky %0b expected 0 0 0 0000 0", bus.mem_req, busy, grant_id, bus.m_rdy, err_sticky); end
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'hFFFF;
        tick();
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b0000 || busy !== 1'b0 || bus.m_rdata !== 64'h0) begin n_errors++; $display("FAIL rst_stray_rdy: got rdy %b busy %0b rdata %h expected 0000 0 0", bus.m_rdy, busy, bus.m_rdata); end
        set_lane(3, 64'h3000, 64'h0);
        bus.m_req = 4'b1000;
        tick();  // ISSUE
        bus.m_req = 4'b0000;
        n_checks++; if (grant_id !== 2'd3 || bus.mem_addr !== 64'h3000 || bus.mem_req !== 1'b1) begin n_errors++; $display("FAIL rst_req3_issue: got grant %0d addr %h req %0b expected 3 3000 1", grant_id, bus.mem_addr, bus.mem_req); end
        bus.mem_rdy = 1'b1;  // completion sampled in the ISSUE cycle
        bus.mem_din = 64'h77;
        tick();  // DONE
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b1000 || bus.m_rdata !== 64'h77 || state !== 2'd3) begin n_errors++; $display("FAIL rst_req3_done: got rdy %b rdata %h state %0d expected 1000 77 3", bus.m_rdy, bus.m_rdata, state); end
        tick();  // IDLE
    endtask

    task automatic test_late_rdy_dropped_req();
        set_lane(1, 64'h1111, 64'h0);
        bus.m_wr  = 4'b0000;
        bus.m_req = 4'b0010;
        tick();  // ISSUE
        n_checks++; if (grant_id !== 2'd1) begin n_errors++; $display("FAIL late_grant: got %0d expected 1", grant_id); end
        tick();  // WAIT1: requester gives up its level
        bus.m_req = 4'b0000;
        tick();  // WAIT2
        tick();  // WAIT3
        n_checks++; if (bus.mem_req !== 1'b1 || busy !== 1'b1 || bus.mem_addr !== 64'h1111) begin n_errors++; $display("FAIL late_hold: got req %0b busy %0b addr %h expected 1 1 1111", bus.mem_req, busy, bus.mem_addr); end
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'hABCD;
        tick();  // DONE
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b0010 || bus.m_rdata !== 64'hABCD) begin n_errors++; $display("FAIL late_done: got rdy %b rdata %h expected 0010 abcd", bus.m_rdy, bus.m_rdata); end
        tick();  // IDLE
        bus.mem_rdy = 1'b1;
        bus.mem_din = 64'h9999;
        tick();
        bus.mem_rdy = 1'b0;
        n_checks++; if (bus.m_rdy !== 4'b0000 || busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.m_rdata !== 64'hABCD) begin n_errors++; $display("FAIL late_stray_idle: got rdy %b busy %0b req %0b rdata %h expected 0000 0 0 abcd", bus.m_rdy, busy, bus.mem_req, bus.m_rdata); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst         = 1'b1;
        bus.m_req   = '0;
        bus.m_wr    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.mem_rdy = 1'b0;
        bus.mem_din = '0;

        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_timeout();
        test_reset_mid_op();
        test_late_rdy_dropped_req();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
